// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, synchronous-read memory between the
// instruction-fetch port (if_*) and the load/store port (d_*).
//
// Each cycle at most one requester is granted and the memory port is driven
// combinationally from the granted request. Read data returns one cycle
// later, steered by a registered owner tag.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   if_req/if_addr      fetch read request; if_gnt accept, if_rvalid/if_rdata response
//   d_req/d_we/d_be/    data request (read or byte-enabled write);
//   d_addr/d_wdata      d_gnt accept, d_rvalid/d_rdata response (reads only)
//   mem_en/mem_we/      memory port driven this cycle
//   mem_be/mem_addr/
//   mem_wdata
//   mem_rdata           memory read data, valid the cycle after a read
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin on contention (last-granted register)
//              undefined -> data priority with a MAX_WAIT fetch starvation guard
module mem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnD    = 2'd2
  } owner_e;

  owner_e     owner_q, owner_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

`ifdef ARB_RR_EN
  // 1 = fetch was the most recent grant; resets to data so fetch wins first.
  logic last_if_q, last_if_d;
`else
  localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);
`endif

  // Grant selection. Reset gates every grant so nothing reaches memory.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (if_req && d_req) begin
`ifdef ARB_RR_EN
        if (last_if_q) begin
          d_gnt = 1'b1;
        end else begin
          if_gnt = 1'b1;
        end
`else
        if (wait_cnt_q == MaxWaitCnt) begin
          if_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
`endif
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

  // Memory port drive; idle cycles present all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_be    = '1;
      mem_addr  = if_addr;
    end
  end

  // Next-state: owner, wait counter, last-granted.
  always_comb begin
    owner_d = OwnNone;
    if (if_gnt) begin
      owner_d = OwnIf;
    end else if (d_gnt && !d_we) begin
      owner_d = OwnD;
    end

`ifdef ARB_RR_EN
    wait_cnt_d = '0;
    last_if_d  = last_if_q;
    if (if_gnt) begin
      last_if_d = 1'b1;
    end else if (d_gnt) begin
      last_if_d = 1'b0;
    end
`else
    wait_cnt_d = wait_cnt_q;
    if (!if_req || if_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MaxWaitCnt) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OwnNone;
      wait_cnt_q <= '0;
`ifdef ARB_RR_EN
      last_if_q  <= 1'b0;
`endif
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
`ifdef ARB_RR_EN
      last_if_q  <= last_if_d;
`endif
    end
  end

  // Responses; a reset clears owner_q asynchronously, dropping any pending read.
  always_comb begin
    if_rvalid = (owner_q == OwnIf);
    d_rvalid  = (owner_q == OwnD);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  typedef struct packed {
    logic          is_if;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents as a pure function of the address.
  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  // Synchronous-read memory; non-read cycles return junk that must be masked.
  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? rd(mem_addr) : 32'hBAD0_BAD0;
  end

  // Protocol: a request may only drop once it has been granted.
  logic if_pend, d_pend;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if_pend <= 1'b0;
      d_pend  <= 1'b0;
    end else begin
      if (if_pend) assert (if_req) else $error("protocol: if_req dropped before grant");
      if (d_pend) assert (d_req) else $error("protocol: d_req dropped before grant");
      if_pend <= if_req && !if_gnt;
      d_pend  <= d_req && !d_gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                       input logic dw, input logic [BW-1:0] db, input logic [AW-1:0] da,
                       input logic [DW-1:0] dd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_be    = db;
    d_addr  = da;
    d_wdata = dd;
  endtask

  // One clock cycle: check grants, memory drive and responses at the falling
  // edge, queue the expected read response, then step past the rising edge.
  task automatic cycle(input string tag, input logic eig, input logic edg);
    rsp_t          r;
    logic          vi, vd;
    logic [DW-1:0] xi, xd;
    @(negedge clk);
    chk({tag, ".if_gnt"}, 64'(if_gnt), 64'(eig));
    chk({tag, ".d_gnt"}, 64'(d_gnt), 64'(edg));
    chk({tag, ".mem_en"}, 64'(mem_en), 64'(eig | edg));
    if (eig) begin
      chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(if_addr));
      chk({tag, ".mem_we"}, 64'(mem_we), 64'(0));
      chk({tag, ".mem_be"}, 64'(mem_be), 64'(4'hF));
      chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(0));
    end else if (edg) begin
      chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(d_addr));
      chk({tag, ".mem_we"}, 64'(mem_we), 64'(d_we));
      chk({tag, ".mem_be"}, 64'(mem_be), 64'(d_be));
      chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(d_wdata));
    end else begin
      chk({tag, ".mem_idle"}, {mem_addr, mem_wdata}, 64'(0));
      chk({tag, ".mem_idle_ctl"}, 64'({mem_we, mem_be}), 64'(0));
    end
    vi = 1'b0;
    vd = 1'b0;
    xi = '0;
    xd = '0;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      if (r.is_if) begin
        vi = 1'b1;
        xi = r.data;
      end else begin
        vd = 1'b1;
        xd = r.data;
      end
    end
    chk({tag, ".if_rvalid"}, 64'(if_rvalid), 64'(vi));
    chk({tag, ".d_rvalid"}, 64'(d_rvalid), 64'(vd));
    chk({tag, ".if_rdata"}, 64'(if_rdata), 64'(xi));
    chk({tag, ".d_rdata"}, 64'(d_rdata), 64'(xd));
    if (!rst) begin
      if (eig) begin
        exp_q.push_back('{is_if: 1'b1, data: rd(if_addr)});
      end else if (edg && !d_we) begin
        exp_q.push_back('{is_if: 1'b0, data: rd(d_addr)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit gseq[$];
    int k;

    // Reset with both requests up: nothing may be granted.
    rst = 1'b1;
    drive(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    cycle("rst0", 1'b0, 1'b0);
    cycle("rst1", 1'b0, 1'b0);
    chk("rst.wait_cnt", 64'(dut.wait_cnt_q), 64'(0));
    rst = 1'b0;

    // Continuous contention straight out of reset.
`ifdef ARB_RR_EN
    gseq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    gseq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    k = 0;
    foreach (gseq[i]) begin
      drive(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h1000 + 32'(4 * k), 32'h0);
      cycle($sformatf("cont%0d", i), gseq[i], !gseq[i]);
      if (!gseq[i]) k++;
    end
    drive(1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle("cont_if", 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle("cont_drain", 1'b0, 1'b0);

    // Fetch only, then a fetch at the top of the address space.
    drive(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle("fetch", 1'b1, 1'b0);
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle("fetch_wrap", 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle("fetch_rsp", 1'b0, 1'b0);

    // Byte-enabled data write: no response follows.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h2000, 32'h1234);
    cycle("wr", 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle("wr_rsp", 1'b0, 1'b0);

    // Back-to-back data reads, then fetch followed directly by a data read.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    cycle("b2b0", 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
    cycle("b2b1", 1'b0, 1'b1);
    drive(1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle("swap_if", 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
    cycle("swap_d", 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle("swap_rsp", 1'b0, 1'b0);

    // Fetch granted, then reset: its response must be dropped.
    drive(1'b1, 32'h180, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle("pre_rst", 1'b1, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle("in_rst", 1'b0, 1'b0);
    chk("in_rst.wait_cnt", 64'(dut.wait_cnt_q), 64'(0));
    rst = 1'b0;
    cycle("post_rst0", 1'b0, 1'b0);
    cycle("post_rst1", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-port, synchronous-read memory between the instruction-fetch port and the load/store port of the core. It is the step that lets instruction ROM and data RAM merge into one unified memory for the multi-cycle and pipelined core variants. Each cycle it grants at most one requester and drives the memory port combinationally. It returns read data to the granted requester one cycle later, tagged by a registered owner. Fetch starvation is bounded by a wait counter, or is avoided by round-robin when configured.

## Interface
- AW, 32, address width
- DW, 32, data width; must be a multiple of 8
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch is forced a grant (fixed-priority mode only); range 1..15

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request; held with if_addr stable until if_gnt
- if_addr  in  AW  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- d_req  in  1  data request; held stable until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_be  in  DW/8  byte enables for writes
- d_addr  in  AW  data byte address
- d_wdata  in  DW  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid (reads only)
- d_rdata  out  DW  data read data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_be  out  DW/8  memory byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0

## Operation
- Grant logic is combinational from the requests and the registered state. At most one of if_gnt and d_gnt is 1.
  - Only one requester active: that requester is granted.
  - No requester active: no grant, and mem_en=0.
- Memory drive:
  - mem_en = if_gnt | d_gnt.
  - On d_gnt: mem_we=d_we, mem_be=d_be, mem_addr=d_addr, mem_wdata=d_wdata.
  - On if_gnt: mem_we=0, mem_be=all ones, mem_addr=if_addr, mem_wdata=0.
  - No grant: all mem_* outputs are 0.
- Owner register (NONE/IF/D) is loaded every cycle:
  - IF on a fetch grant.
  - D on a data read grant.
  - NONE otherwise, including data writes.
- Responses:
  - if_rvalid = (owner==IF); d_rvalid = (owner==D).
  - x_rdata = mem_rdata when x_rvalid is 1, else 0.
- Writes complete on grant and produce no rvalid.
- Contention resolution, fixed-priority mode: data wins, except when wait_cnt==MAX_WAIT, in which case fetch wins.
- wait_cnt (4 bit):
  - Increments when if_req=1 and if_gnt=0.
  - Clears on if_gnt or when if_req=0.
  - Saturates at MAX_WAIT.
- A new grant is permitted in the same cycle a response is returned, giving back-to-back throughput of one access per cycle.

## Timing
- Reset values: owner=NONE, wait_cnt=0, last=D. While rst=1: if_gnt=0, d_gnt=0, mem_en=0, both rvalid=0, both rdata=0.
- Grant to rvalid latency: exactly 1 cycle.
- Reset asserted with a read outstanding: the response is dropped and no rvalid is issued after reset release.
- Request deasserted in the same cycle as its grant: legal; the access still occurs.
- Request deasserted before a grant: illegal; behaviour is undefined. The bench asserts this as a protocol check.
- Address and data wrap follows the AW-bit values unchanged; the arbiter performs no arithmetic on addresses.

## Configuration
- ARB_RR_EN defined:
  - Round-robin on contention: the requester not granted last wins.
  - The last register updates on every grant and resets to D, so fetch wins the first contention.
  - wait_cnt is held at 0 and MAX_WAIT is ignored.
- ARB_RR_EN undefined: fixed data priority with the MAX_WAIT starvation guard as described above. The last register is absent.

## Test plan
- Fetch only: if_req=1, if_addr=0x100; mem_rdata=0xDEADBEEF one cycle later.
  - Cycle 0: if_gnt=1, mem_addr=0x100, mem_we=0.
  - Cycle 1: if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- Data write: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x2000, d_wdata=0x1234.
  - Cycle 0: d_gnt=1, mem_we=1, mem_be=4'b0011.
  - Cycle 1: no rvalid.
- Fixed mode, continuous contention with MAX_WAIT=4 (both requests held for 6 cycles, data re-requests after each grant): grants are D,D,D,D,IF,D. if_rvalid appears in cycle 5 only.
- ARB_RR_EN mode, continuous contention from reset: grants are IF,D,IF,D. Each rvalid goes to the correct owner one cycle after its grant.
- Back-to-back data reads at 0x10, then 0x14: d_gnt in cycles 0 and 1; d_rvalid in cycles 1 and 2 with the matching mem_rdata.
- Fetch granted in cycle 0, rst pulsed in cycle 1: if_rvalid=0 in cycle 1 and in all cycles after release until a new grant; wait_cnt=0.
